// File: rtl/alu_md_if.sv
// Request/response bundle between the EX-stage control and the integer execute unit.
interface alu_md_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output flush, in_valid, alu_op, funct3, funct7, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  flush, in_valid, alu_op, funct3, funct7, op_a, op_b, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/alu_md_exec.sv
// Integer execute unit: single-cycle base ALU plus an iterative RV32M
// multiply (shift-add) / divide (restoring) engine behind a valid/ready handshake.
module alu_md_exec #(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     rst,
    alu_md_if.slave  bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_main_q, neg_main_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              out_valid_q, out_valid_d;

    logic [XLEN-1:0]   a, b;
    logic [CW-1:0]     shamt;
    logic [2:0]        f3_eff;
    logic              sub_sel, sra_sel, is_m;
    logic [XLEN-1:0]   base_res;

    logic              signed_a, signed_b, sign_a, sign_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   special_res;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN+1:0]   div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] prod_fin;
    logic [XLEN-1:0]   quot_fin, rem_fin, fin_res;

    logic              in_ready, accept;

    assign a     = bus.op_a;
    assign b     = bus.op_b;
    assign shamt = bus.op_b[CW-1:0];

    assign in_ready      = (state_q == IDLE) && (!out_valid_q || bus.out_ready) && !bus.flush;
    assign accept        = bus.in_valid && in_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.busy      = (state_q != IDLE);

    // Decode the base ALU operation and compute its single-cycle result.
    always_comb begin
        is_m     = (bus.alu_op == 2'b10) && (bus.funct7 == 7'b0000001);
        f3_eff   = bus.funct3;
        sub_sel  = 1'b0;
        sra_sel  = 1'b0;
        base_res = '0;
        case (bus.alu_op)
            2'b00: f3_eff = 3'b000;
            2'b01: begin
                f3_eff  = 3'b000;
                sub_sel = 1'b1;
            end
            2'b10: begin
                if (bus.funct7 == 7'b0000000 || bus.funct7 == 7'b0100000) begin
                    sub_sel = bus.funct7[5];
                    sra_sel = bus.funct7[5];
                end else begin
                    f3_eff = 3'b000;
                end
            end
            default: sra_sel = bus.funct7[5];
        endcase
        case (f3_eff)
            3'b000: base_res = sub_sel ? (a - b) : (a + b);
            3'b111: base_res = a & b;
            3'b110: base_res = a | b;
            3'b100: base_res = a ^ b;
            3'b001: base_res = a << shamt;
            3'b101: base_res = sra_sel ? $unsigned($signed(a) >>> shamt) : (a >> shamt);
            3'b010: base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            default: base_res = {{(XLEN-1){1'b0}}, (a < b)};
        endcase
    end

    // Prepare operand magnitudes, result signs and the divide corner cases for an M op.
    always_comb begin
        signed_a    = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                      (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        signed_b    = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        sign_a      = signed_a && a[XLEN-1];
        sign_b      = signed_b && b[XLEN-1];
        mag_a       = sign_a ? -a : a;
        mag_b       = sign_b ? -b : b;
        div_zero    = bus.funct3[2] && (b == '0);
        div_ovf     = bus.funct3[2] && signed_b && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        special_res = '0;
        if (div_zero) begin
            special_res = bus.funct3[1] ? a : '1;
        end else if (div_ovf) begin
            special_res = bus.funct3[1] ? '0 : a;
        end
    end

    // One iteration of the multiply and divide engines, plus final sign fix-up.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, mcand_q};
        div_next  = div_diff[XLEN+1] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        prod_fin  = neg_main_q ? -acc_q : acc_q;
        quot_fin  = neg_main_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fin   = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (f3_q)
            3'b000:          fin_res = prod_fin[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:          fin_res = prod_fin[2*XLEN-1:XLEN];
            3'b100, 3'b101:  fin_res = quot_fin;
            default:         fin_res = rem_fin;
        endcase
    end

    // Next-state logic: handshake, op launch, iteration count and result load.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        f3_d        = f3_q;
        neg_main_d  = neg_main_q;
        neg_rem_d   = neg_rem_q;
        result_d    = result_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        if (bus.flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (!is_m) begin
                            result_d    = base_res;
                            out_valid_d = 1'b1;
                        end else if (div_zero || div_ovf) begin
                            result_d    = special_res;
                            out_valid_d = 1'b1;
                        end else begin
                            state_d    = CALC;
                            cnt_d      = CW'(XLEN - 1);
                            acc_d      = {{XLEN{1'b0}}, mag_a};
                            mcand_d    = mag_b;
                            f3_d       = bus.funct3;
                            neg_main_d = sign_a ^ sign_b;
                            neg_rem_d  = sign_a;
                        end
                    end
                end
                CALC: begin
                    acc_d = f3_q[2] ? div_next : mul_next;
                    if (cnt_q == '0) begin
                        state_d = FIN;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    result_d    = fin_res;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            f3_q        <= '0;
            neg_main_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            f3_q        <= f3_d;
            neg_main_q  <= neg_main_d;
            neg_rem_q   <= neg_rem_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_alu_md_exec.sv
// Directed bench for alu_md_exec at XLEN=32 and XLEN=16.
module tb_alu_md_exec;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    alu_md_if #(.XLEN(32)) i32 ();
    alu_md_if #(.XLEN(16)) i16 ();

    alu_md_exec #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .bus(i32.slave));
    alu_md_exec #(.XLEN(16)) dut16 (.clk(clk), .rst(rst), .bus(i16.slave));

    always #5 clk = ~clk;

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive32(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] a, input logic [31:0] b);
        i32.alu_op   = op;
        i32.funct3   = f3;
        i32.funct7   = f7;
        i32.op_a     = a;
        i32.op_b     = b;
        i32.in_valid = 1'b1;
    endtask

    // Issue one M op; edges counts rising edges after the accepting edge until
    // out_valid shows (0 means the result came with the accept edge itself).
    task automatic run_m32(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output int edges, output int busy_cyc);
        drive32(2'b10, f3, 7'b0000001, a, b);
        tick();
        i32.in_valid = 1'b0;
        edges    = 0;
        busy_cyc = 0;
        while (!i32.out_valid && edges < 200) begin
            if (i32.busy) busy_cyc++;
            tick();
            edges++;
        end
        res = i32.result;
    endtask

    task automatic run_m16(input logic [2:0] f3, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] res, output int edges, output int busy_cyc);
        i16.alu_op   = 2'b10;
        i16.funct3   = f3;
        i16.funct7   = 7'b0000001;
        i16.op_a     = a;
        i16.op_b     = b;
        i16.in_valid = 1'b1;
        tick();
        i16.in_valid = 1'b0;
        edges    = 0;
        busy_cyc = 0;
        while (!i16.out_valid && edges < 100) begin
            if (i16.busy) busy_cyc++;
            tick();
            edges++;
        end
        res = i16.result;
    endtask

    task automatic test_reset();
        i32.flush = 1'b0; i32.in_valid = 1'b0; i32.out_ready = 1'b1;
        i32.alu_op = '0; i32.funct3 = '0; i32.funct7 = '0; i32.op_a = '0; i32.op_b = '0;
        i16.flush = 1'b0; i16.in_valid = 1'b0; i16.out_ready = 1'b1;
        i16.alu_op = '0; i16.funct3 = '0; i16.funct7 = '0; i16.op_a = '0; i16.op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (i32.out_valid !== 1'b0 || i32.busy !== 1'b0 || i32.result !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: valid=%b busy=%b result=%h, want 0/0/0",
                     i32.out_valid, i32.busy, i32.result);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (i32.in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_in_ready: got %b want 1", i32.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ops [4] = '{2'b00, 2'b10, 2'b11, 2'b10};
        logic [2:0]  f3s [4] = '{3'b000, 3'b000, 3'b101, 3'b011};
        logic [6:0]  f7s [4] = '{7'h00, 7'h20, 7'h20, 7'h00};
        logic [31:0] as  [4] = '{32'd5, 32'd3, 32'h8000_0000, 32'd1};
        logic [31:0] bs  [4] = '{32'd7, 32'd5, 32'd4, 32'hFFFF_FFFF};
        logic [31:0] exp [4] = '{32'd12, 32'hFFFF_FFFE, 32'hF800_0000, 32'd1};
        i32.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive32(ops[i], f3s[i], f7s[i], as[i], bs[i]);
            tick();
            vectors++;
            if (i32.out_valid !== 1'b1 || i32.result !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL base_op%0d: valid=%b result=%h, want 1/%h",
                         i, i32.out_valid, i32.result, exp[i]);
            end
        end
        i32.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_mul();
        logic [2:0]  f3s [4] = '{3'b001, 3'b011, 3'b010, 3'b000};
        logic [31:0] as  [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7};
        logic [31:0] bs  [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        logic [31:0] exp [4] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        logic [31:0] res;
        int edges, busy_cyc;
        for (int i = 0; i < 4; i++) begin
            run_m32(f3s[i], as[i], bs[i], res, edges, busy_cyc);
            vectors++;
            if (res !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL mul%0d_result: got %h want %h", i, res, exp[i]);
            end
            vectors++;
            if (edges !== 33 || busy_cyc !== 33) begin
                miscompares++;
                $display("[TB] FAIL mul%0d_timing: latency=%0d busy=%0d, want 33/33", i, edges, busy_cyc);
            end
        end
        vectors++;
        if (i32.busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mul_busy_after: got %b want 0", i32.busy);
        end
    endtask

    task automatic test_divide();
        logic [2:0]  f3s [8] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
        logic [31:0] as  [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                 32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [8] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                                 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                 32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000, 32'd0};
        int          lat [8] = '{33, 33, 33, 33, 0, 0, 0, 0};
        logic [31:0] res;
        int edges, busy_cyc;
        for (int i = 0; i < 8; i++) begin
            run_m32(f3s[i], as[i], bs[i], res, edges, busy_cyc);
            vectors++;
            if (res !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL div%0d_result: got %h want %h", i, res, exp[i]);
            end
            vectors++;
            if (edges !== lat[i] || busy_cyc !== lat[i]) begin
                miscompares++;
                $display("[TB] FAIL div%0d_timing: latency=%0d busy=%0d, want %0d/%0d",
                         i, edges, busy_cyc, lat[i], lat[i]);
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        i32.out_ready = 1'b0;
        drive32(2'b00, 3'b000, 7'h00, 32'd1, 32'd1);
        tick();
        drive32(2'b10, 3'b100, 7'h00, 32'h0000_00F0, 32'h0000_00FF);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (i32.in_ready !== 1'b0 || i32.out_valid !== 1'b1 || i32.result !== 32'd2) begin
                miscompares++;
                $display("[TB] FAIL hold%0d: in_ready=%b valid=%b result=%h, want 0/1/2",
                         i, i32.in_ready, i32.out_valid, i32.result);
            end
            tick();
        end
        i32.out_ready = 1'b1;
        #1;
        vectors++;
        if (i32.in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL release_in_ready: got %b want 1", i32.in_ready);
        end
        tick();
        vectors++;
        if (i32.out_valid !== 1'b1 || i32.result !== 32'h0000_000F) begin
            miscompares++;
            $display("[TB] FAIL release_result: valid=%b result=%h, want 1/0000000f",
                     i32.out_valid, i32.result);
        end
        i32.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        int seen = 0;
        drive32(2'b10, 3'b101, 7'b0000001, 32'd1000, 32'd3);
        tick();
        i32.in_valid = 1'b0;
        repeat (9) tick();
        i32.flush = 1'b1;
        drive32(2'b00, 3'b000, 7'h00, 32'd9, 32'd9);
        #1;
        vectors++;
        if (i32.in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_in_ready: got %b want 0", i32.in_ready);
        end
        tick();
        i32.flush    = 1'b0;
        i32.in_valid = 1'b0;
        vectors++;
        if (i32.busy !== 1'b0 || i32.out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_idle: busy=%b valid=%b, want 0/0", i32.busy, i32.out_valid);
        end
        for (int i = 0; i < 40; i++) begin
            if (i32.out_valid) seen++;
            tick();
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("[TB] FAIL flush_no_result: out_valid seen %0d times, want 0", seen);
        end
        drive32(2'b00, 3'b000, 7'h00, 32'd20, 32'd22);
        tick();
        i32.in_valid = 1'b0;
        vectors++;
        if (i32.out_valid !== 1'b1 || i32.result !== 32'd42) begin
            miscompares++;
            $display("[TB] FAIL flush_then_add: valid=%b result=%h, want 1/0000002a",
                     i32.out_valid, i32.result);
        end
        tick();
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        int edges, busy_cyc;
        drive32(2'b10, 3'b000, 7'b0000001, 32'd3, 32'd5);
        tick();
        i32.in_valid = 1'b0;
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (i32.out_valid !== 1'b0 || i32.busy !== 1'b0 || i32.result !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: valid=%b busy=%b result=%h, want 0/0/0",
                     i32.out_valid, i32.busy, i32.result);
        end
        #1;
        rst = 1'b0;
        tick();
        vectors++;
        if (i32.out_valid !== 1'b0 || i32.in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL after_reset: valid=%b in_ready=%b, want 0/1", i32.out_valid, i32.in_ready);
        end
        run_m32(3'b000, 32'h0000_1234, 32'h0000_0100, res, edges, busy_cyc);
        vectors++;
        if (res !== 32'h0012_3400 || edges !== 33) begin
            miscompares++;
            $display("[TB] FAIL mul_after_reset: result=%h latency=%0d, want 00123400/33", res, edges);
        end
        tick();
    endtask

    task automatic test_xlen16();
        logic [2:0]  f3s [8] = '{3'b011, 3'b000, 3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b100};
        logic [15:0] as  [8] = '{16'hFFFF, 16'd7, 16'hFFF9, 16'hFFF9, 16'd100, 16'd100, 16'h0055, 16'h8000};
        logic [15:0] bs  [8] = '{16'hFFFF, 16'hFFFD, 16'd2, 16'd2, 16'd7, 16'd7, 16'd0, 16'hFFFF};
        logic [15:0] exp [8] = '{16'hFFFE, 16'hFFEB, 16'hFFFD, 16'hFFFF, 16'd14, 16'd2, 16'hFFFF, 16'h8000};
        int          lat [8] = '{17, 17, 17, 17, 17, 17, 0, 0};
        logic [15:0] res;
        int edges, busy_cyc;
        for (int i = 0; i < 8; i++) begin
            run_m16(f3s[i], as[i], bs[i], res, edges, busy_cyc);
            vectors++;
            if (res !== exp[i]) begin
                miscompares++;
                $display("[TB] FAIL x16_op%0d_result: got %h want %h", i, res, exp[i]);
            end
            vectors++;
            if (edges !== lat[i] || busy_cyc !== lat[i]) begin
                miscompares++;
                $display("[TB] FAIL x16_op%0d_timing: latency=%0d busy=%0d, want %0d/%0d",
                         i, edges, busy_cyc, lat[i], lat[i]);
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_mul();
        test_divide();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_xlen16();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/alu_md_exec.md
# alu_md_exec

Parametrised integer execute unit for the EX stage. It decodes `alu_op`/`funct3`/`funct7` with the team's existing ALU encoding, extended with the RV32M multiply/divide group. It executes the operation and returns a registered result over a valid/ready handshake. Base ALU ops complete in 1 cycle. M-extension ops run on an iterative shift-add / restoring-divide engine, and the pipeline hazard unit stalls on `busy`.

## Interface
- `XLEN`, default 32: operand/result width; must be a power of 2, ≥ 8. Shift amount is `op_b[$clog2(XLEN)-1:0]`.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `flush` input 1: synchronous squash; aborts any op and drops any held result.
- `in_valid` input 1: request present.
- `in_ready` output 1: unit accepts a request this cycle.
- `alu_op` input 2: 00 = ADD, 01 = SUB, 10 = R-type, 11 = I-type.
- `funct3` input 3: instruction funct3.
- `funct7` input 7: instruction funct7 (I-type: imm[11:5]).
- `op_a` input XLEN: rs1 value.
- `op_b` input XLEN: rs2 value or immediate.
- `out_valid` output 1: `result` is valid.
- `out_ready` input 1: consumer takes the result.
- `result` output XLEN: operation result.
- `busy` output 1: high while an iterative op is in flight (state CALC or FIN).

## Operation
- Accept condition: `in_valid && in_ready` at a rising edge.
- `in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush`.
- Base decode:
  - alu_op 00 → ADD; 01 → SUB.
  - alu_op 10 with funct7 = 0000000 or 0100000: funct3 000 ADD/SUB (funct7[5]), 111 AND, 110 OR, 100 XOR, 001 SLL, 101 SRL/SRA (funct7[5]), 010 SLT (signed), 011 SLTU.
  - alu_op 11: same table, but funct3 000 is always ADD; funct7[5] is honoured only for funct3 101.
- M decode: alu_op 10 and funct7 = 0000001. funct3 selects 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Any other funct7 with alu_op 10 → ADD.
- States: IDLE, CALC, FIN.
- IDLE, accept of a base op: `result` is registered and `out_valid` is set at the same edge; state stays IDLE.
- IDLE, accept of an M op: operand magnitudes and result sign are latched per signedness, `cnt` ← XLEN-1, state → CALC. Special cases bypass CALC and are registered directly, latency 1:
  - divisor zero → quotient all-ones, remainder = op_a;
  - signed overflow (op_a = 2^(XLEN-1), op_b = -1) → quotient = op_a, remainder = 0.
- CALC: one iteration per cycle.
  - Multiply: shift-add into a 2·XLEN accumulator.
  - Divide: restoring; one quotient bit per cycle.
  - When `cnt == 0`, state → FIN; otherwise `cnt` ← `cnt - 1`.
- FIN: conditional two's-complement negation is applied. MUL takes the low half; MULH/MULHSU/MULHU take the high half; DIV/REM give quotient/remainder.
  - Remainder sign = dividend sign; quotient sign = XOR of operand signs.
  - Result is registered, `out_valid` ← 1, state → IDLE.
- Output hold: while `out_valid && !out_ready`, `result` is stable and no new request is accepted.
- `out_valid` clears on a handshake unless a new result is loaded at the same edge (back-to-back base ops allowed).
- `flush`: at the next edge `out_valid` ← 0 and state → IDLE, regardless of state; a same-cycle `in_valid` is ignored.

## Timing
- Reset values: state IDLE, `out_valid` 0, `result` 0, `busy` 0, `cnt` 0. `in_ready` reads 1 immediately after reset deassertion.
- `rst` mid-CALC aborts asynchronously; no stale `out_valid` after release.
- Base op latency: 1 cycle; throughput 1/cycle when `out_ready` is held high.
- M op latency: XLEN+1 cycles from accept to `out_valid` (33 at XLEN=32). Special-case divides take 1 cycle.
- `busy` is high from the edge after accept until the FIN edge, exactly XLEN+1 cycles.

## Test plan
- Reset then base ops back-to-back with `out_ready` = 1:
  - ADD 5 + 7 → 12 at cycle 1;
  - SUB (alu_op 10, funct7 0100000) 3 - 5 → 0xFFFFFFFE;
  - SRA I-type 0x80000000 >>> 4 → 0xF8000000;
  - SLTU 1 vs 0xFFFFFFFF → 1.
  - One result per cycle.
- MUL group, XLEN = 32:
  - MULH 0x80000000 × 0x80000000 → 0x40000000;
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE;
  - MULHSU -1 × 0xFFFFFFFF → 0xFFFFFFFF;
  - MUL 7 × -3 → 0xFFFFFFEB.
  - `out_valid` exactly 33 cycles after accept; `busy` high for 33 cycles.
- Divide:
  - DIV -7 / 2 → 0xFFFFFFFD and REM → 0xFFFFFFFF;
  - DIVU 100 / 7 → 14, REMU → 2;
  - DIV by 0 → 0xFFFFFFFF and REM by 0 → op_a, both at latency 1;
  - DIV 0x80000000 / -1 → 0x80000000 and REM → 0, both at latency 1.
- Backpressure: `out_ready` = 0 for 5 cycles after a result → `result` stable, `in_ready` = 0, the next `in_valid` is held off; accepted on the cycle `out_ready` rises.
- Flush at cycle 10 of a DIVU → IDLE next edge, no `out_valid`, `busy` = 0; a following ADD returns its correct value at latency 1.
- Async `rst` pulse mid-MUL (between edges) → all outputs go to reset values immediately; a MUL issued after release gives the correct product at latency 33.
- Repeat the MUL and divide checks at XLEN = 16: latency 17, MULHU 0xFFFF × 0xFFFF → 0xFFFE.
